// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 types and constants for the PRGA stage and the crack checker
package arc4_pkg;

  localparam int MEM_DEPTH = 256;

  // Printable ASCII window; the crack checker uses the same bounds.
  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RD_LEN   = 4'd1,
    ST_WR_LEN   = 4'd2,
    ST_RD_SI    = 4'd3,
    ST_WAIT_SI  = 4'd4,
    ST_WAIT_SJ  = 4'd5,
    ST_WR_SI    = 4'd6,
    ST_WR_SJ    = 4'd7,
    ST_RD_PAD   = 4'd8,
    ST_WAIT_PAD = 4'd9
  } prga_state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_MIN) && (b <= ASCII_MAX);
  endfunction

endpackage

// File: rtl/prga.sv
// rtl/prga.sv - ARC4 PRGA stage: decrypts a length-prefixed CT message into PT memory (option macro: PRGA_EARLY_ABORT_EN)
module prga
  import arc4_pkg::*;
#(
  parameter int MSG_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [MSG_AW-1:0] s_addr,
  input  logic [7:0]        s_rddata,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  output logic [MSG_AW-1:0] ct_addr,
  input  logic [7:0]        ct_rddata,
  output logic [MSG_AW-1:0] pt_addr,
  output logic [7:0]        pt_wrdata,
  output logic              pt_wren,
  output logic              pt_bad
);

  prga_state_t state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic [7:0]  ctb_q, ctb_d;
  logic [7:0]  pad_byte;

  // Keystream byte arrives from S in WAIT_PAD; combine with the latched CT byte.
  assign pad_byte = s_rddata ^ ctb_q;

`ifdef PRGA_EARLY_ABORT_EN
  logic bad_q, bad_d;
  assign pt_bad = bad_q;
`else
  assign pt_bad = 1'b0;
`endif

  // State and datapath registers; outputs are decoded from state so reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      ctb_q   <= '0;
`ifdef PRGA_EARLY_ABORT_EN
      bad_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ctb_q   <= ctb_d;
`ifdef PRGA_EARLY_ABORT_EN
      bad_q   <= bad_d;
`endif
    end
  end

  // Next-state: one message walk, seven cycles per ciphertext byte.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    len_d   = len_q;
    si_d    = si_q;
    sj_d    = sj_q;
    ctb_d   = ctb_q;
`ifdef PRGA_EARLY_ABORT_EN
    bad_d   = bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = 8'd1;
`ifdef PRGA_EARLY_ABORT_EN
          bad_d   = 1'b0;
`endif
          state_d = ST_RD_LEN;
        end
      end
      ST_RD_LEN: begin
        len_d   = ct_rddata;
        state_d = ST_WR_LEN;
      end
      ST_WR_LEN: begin
        state_d = (len_q == 8'd0) ? ST_IDLE : ST_RD_SI;
      end
      ST_RD_SI: begin
        i_d     = i_q + 8'd1;
        state_d = ST_WAIT_SI;
      end
      ST_WAIT_SI: begin
        si_d    = s_rddata;
        ctb_d   = ct_rddata;
        j_d     = j_q + s_rddata;
        state_d = ST_WAIT_SJ;
      end
      ST_WAIT_SJ: begin
        sj_d    = s_rddata;
        state_d = ST_WR_SI;
      end
      ST_WR_SI:  state_d = ST_WR_SJ;
      ST_WR_SJ:  state_d = ST_RD_PAD;
      ST_RD_PAD: state_d = ST_WAIT_PAD;
      ST_WAIT_PAD: begin
        // Comparing before incrementing lets len=255 finish without k wrapping.
        if (k_q == len_q) begin
          state_d = ST_IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = ST_RD_SI;
        end
`ifdef PRGA_EARLY_ABORT_EN
        // The offending byte is still written so the checker sees it, then the walk stops.
        if (!is_printable(pad_byte)) begin
          bad_d   = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory-side outputs decoded from the current state; idle values are all zero.
  always_comb begin
    rdy       = (state_q == ST_IDLE);
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state_q)
      ST_WR_LEN: begin
        pt_wrdata = len_q;
        pt_wren   = 1'b1;
      end
      ST_RD_SI: begin
        s_addr  = MSG_AW'(i_q + 8'd1);
        ct_addr = MSG_AW'(k_q);
      end
      ST_WAIT_SI: begin
        // j is not yet updated here, so form j+S[i] directly from the read data.
        s_addr = MSG_AW'(j_q + s_rddata);
      end
      ST_WR_SI: begin
        s_addr   = MSG_AW'(i_q);
        s_wrdata = sj_q;
        s_wren   = 1'b1;
      end
      ST_WR_SJ: begin
        s_addr   = MSG_AW'(j_q);
        s_wrdata = si_q;
        s_wren   = 1'b1;
      end
      ST_RD_PAD: begin
        s_addr = MSG_AW'(si_q + sj_q);
      end
      ST_WAIT_PAD: begin
        pt_addr   = MSG_AW'(k_q);
        pt_wrdata = pad_byte;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/prga.md
Name: prga

Overview:
- Pseudo-random generation stage of the ARC4 datapath. It sits directly upstream of the crack plaintext checker.
- Starts from an S-box already permuted by the key-scheduling stage and walks a length-prefixed ciphertext message.
- XORs each ciphertext byte with the keystream and streams plaintext bytes into PT memory.
- The checker snoops the pt_wren/pt_addr/pt_wrdata writes to judge each key.

Parameters:
- MSG_AW, 8, address width of CT/PT/S memories (256 entries; S-box arithmetic is always mod 256).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; honoured only while rdy=1
- rdy  out  1  idle/ready
- s_addr  out  8  S memory address
- s_rddata  in  8  S read data (1-cycle latency)
- s_wrdata  out  8  S write data
- s_wren  out  1  S write enable
- ct_addr  out  8  CT address
- ct_rddata  in  8  CT read data (1-cycle latency)
- pt_addr  out  8  PT address
- pt_wrdata  out  8  PT write data
- pt_wren  out  1  PT write enable
- pt_bad  out  1  non-printable byte seen (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; i=j=k=len=0.
- Outputs during reset: rdy=1, all *_wren=0, addresses=0, wrdata=0, pt_bad=0.
- Reset mid-message takes effect immediately: wren drops without waiting for a clock edge, and no partial write completes.
- All memories are synchronous-read: the address is presented in cycle N and data is valid in cycle N+1.
- Handshake:
  - rdy=1 only in IDLE.
  - en=1 with rdy=1 at a rising edge starts a message; rdy=0 from the next cycle.
  - en while busy is ignored.
  - rdy returns to 1 in the cycle after the final PT write.
- States and transitions:
  - IDLE: ct_addr=0. On start, i=j=0, k=1, pt_bad=0 -> RD_LEN.
  - RD_LEN: capture len=ct_rddata -> WR_LEN.
  - WR_LEN: pt_addr=0, pt_wrdata=len, pt_wren=1. If len=0 -> IDLE, else -> RD_SI.
  - RD_SI: i=i+1 mod 256; s_addr=i+1; ct_addr=k -> WAIT_SI.
  - WAIT_SI: si=s_rddata; ctb=ct_rddata; j=j+si mod 256; s_addr=j+si -> WAIT_SJ.
  - WAIT_SJ: sj=s_rddata -> WR_SI.
  - WR_SI: s_addr=i, s_wrdata=sj, s_wren=1 -> WR_SJ.
  - WR_SJ: s_addr=j, s_wrdata=si, s_wren=1 -> RD_PAD.
  - RD_PAD: s_addr=(si+sj) mod 256 -> WAIT_PAD.
  - WAIT_PAD: pt_addr=k, pt_wrdata=s_rddata^ctb, pt_wren=1. If k==len -> IDLE, else k=k+1 -> RD_SI.
- Per-byte cost: 7 cycles; total 2+7*len cycles from start to rdy.
- i==j case: the two writes in WR_SI then WR_SJ store the same value, which is correct.
- len=255: k reaches 255 and the block terminates on the compare, with no k overflow.
- Exactly one wren of each memory is high per cycle at most. pt_wren is high for exactly len+1 cycles per message.

Optional Feature:
- Macro: PRGA_EARLY_ABORT_EN.
- Defined:
  - In WAIT_PAD, a plaintext byte with k>=1 outside 0x20..0x7E is still written.
  - pt_bad is set (sticky until next start) and the block goes to IDLE, skipping the remaining bytes.
  - Lets crack reject a key in about 7 cycles instead of a full message.
- Undefined:
  - pt_bad is tied 0.
  - The full message is always processed.

Decomposition:
- Package arc4_pkg:
  - prga_state_t enum.
  - Constants ASCII_MIN=8'h20 and ASCII_MAX=8'h7E, shared with crack's checker.
  - MEM_DEPTH=256.
- Sub-module:
  - None required. The FSM plus datapath registers (i, j, k, len, si, sj, ctb) form one module.
  - The ASCII range test is an inline function in arc4_pkg.

Test Plan:
- Key-scheduling vector:
  - Stimulus: S preloaded with the KSA of key 24'h4B6579 ("Key"); CT={09,BB,F3,16,E8,D9,40,AF,0A,D3}; pulse en.
  - Response: PT={09,"Plaintext"}; rdy high after 65 cycles; 10 PT writes.
- Zero length:
  - Stimulus: ct[0]=00.
  - Response: single write pt[0]=00; no S writes; rdy back after 2 cycles.
- Busy start ignored:
  - Stimulus: hold en=1 throughout the vector above.
  - Response: identical output; exactly one message processed; rdy toggles 1->0->1 once, then it restarts.
- Reset mid-operation:
  - Stimulus: drop rst_n during WR_SI of byte 3.
  - Response: s_wren/pt_wren fall combinationally; rdy=1; a fresh en run on a reloaded S reproduces the correct PT.
- Early abort (macro defined):
  - Stimulus: CT whose byte 2 decrypts to 0x07.
  - Response: pt_bad=1; last write at pt_addr=2; rdy=1 at cycle 16.
  - Same stimulus with the macro undefined: full length processed and pt_bad=0.
